// File: rtl/cordic_vector_engine_if.sv
// Handshake and operand/result bundle for cordic_vector_engine.
//   master: drives ena, start, x_in, y_in; receives busy, done, mag_out, ang_out
//   slave : the engine side of the same signals
//   ena      clock enable, low freezes the engine
//   start    request, sampled while idle
//   x_in     signed x operand (WIDTH bits)
//   y_in     signed y operand (WIDTH bits)
//   busy     computation in flight
//   done     one-cycle pulse, results valid
//   mag_out  unsigned magnitude (WIDTH+1 bits)
//   ang_out  signed angle, 2^16 = full turn
interface cordic_vector_engine_if #(
  parameter int WIDTH = 8
);
  logic                    ena;
  logic                    start;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic                    busy;
  logic                    done;
  logic [WIDTH:0]          mag_out;
  logic [15:0]             ang_out;

  modport master (
    output ena, start, x_in, y_in,
    input  busy, done, mag_out, ang_out
  );

  modport slave (
    input  ena, start, x_in, y_in,
    output busy, done, mag_out, ang_out
  );
endinterface

// File: rtl/cordic_vector_engine.sv
// CORDIC vectoring engine: magnitude sqrt(x^2+y^2) and angle atan2(y,x) of a
// signed (x,y) pair, all four quadrants, optional gain-compensated magnitude.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    cordic_vector_engine_if.slave: ena, start, x_in, y_in in;
//          busy, done, mag_out, ang_out out
// One request takes ITERS+2 enabled cycles: load, ITERS micro-rotations, post.
module cordic_vector_engine #(
  parameter int WIDTH     = 8,
  parameter int FRAC      = 8,
  parameter int ITERS     = 12,
  parameter int GAIN_COMP = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cordic_vector_engine_if.slave  bus
);

  localparam int W  = WIDTH + FRAC + 2;
  localparam int PW = W + 18;
  localparam int CW = 4;

  localparam logic signed [PW-1:0] K_GAIN    = PW'(64'h9B75);
  localparam logic signed [PW-1:0] RND_GAIN  = PW'(64'd1 << (15 + FRAC));
  localparam logic signed [PW-1:0] RND_RAW   = PW'((64'd1 << FRAC) >> 1);
  localparam logic signed [PW-1:0] MAG_MAX_W = PW'((64'd1 << (WIDTH + 1)) - 64'd1);

  localparam logic [15:0] ATAN [16] = '{
    16'h2000, 16'h12E4, 16'h09FB, 16'h0511, 16'h028B, 16'h0146, 16'h00A3, 16'h0051,
    16'h0029, 16'h0014, 16'h000A, 16'h0005, 16'h0003, 16'h0001, 16'h0001, 16'h0000
  };

  typedef enum logic [1:0] {IDLE, ITER, POST} state_t;

  state_t                state_q, state_d;
  logic signed [W-1:0]   x_q, x_d;
  logic signed [W-1:0]   y_q, y_d;
  logic [15:0]           z_q, z_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [WIDTH:0]        mag_q, mag_d;
  logic [15:0]           ang_q, ang_d;
  logic                  on_axis_q, on_axis_d;
  logic                  x_neg_q, x_neg_d;

  logic signed [W-1:0]   x_ext, y_ext;
  logic signed [W-1:0]   x_sh, y_sh;
  logic [15:0]           atan_i;
  logic signed [PW-1:0]  x_wide, scaled;
  logic [WIDTH:0]        mag_sat;

  // Operand extension, shifted rotation terms and the post-scale result.
  always_comb begin
    x_ext  = {{(W-WIDTH){bus.x_in[WIDTH-1]}}, bus.x_in} <<< FRAC;
    y_ext  = {{(W-WIDTH){bus.y_in[WIDTH-1]}}, bus.y_in} <<< FRAC;
    x_sh   = x_q >>> cnt_q;
    y_sh   = y_q >>> cnt_q;
    atan_i = ATAN[cnt_q];
    x_wide = PW'(x_q);
    if (GAIN_COMP != 0) begin
      scaled = (x_wide * K_GAIN + RND_GAIN) >>> (16 + FRAC);
    end else begin
      scaled = (x_wide + RND_RAW) >>> FRAC;
    end
    if (scaled[PW-1]) begin
      mag_sat = '0;
    end else if (scaled > MAG_MAX_W) begin
      mag_sat = '1;
    end else begin
      mag_sat = scaled[WIDTH:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    mag_d     = mag_q;
    ang_d     = ang_q;
    on_axis_d = on_axis_q;
    x_neg_d   = x_neg_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Left half-plane is folded by a 180 degree rotation so the
          // micro-rotations only ever have to cover +/-90 degrees.
          x_neg_d   = bus.x_in[WIDTH-1];
          on_axis_d = (bus.y_in == '0);
          x_d       = bus.x_in[WIDTH-1] ? -x_ext : x_ext;
          y_d       = bus.x_in[WIDTH-1] ? -y_ext : y_ext;
          z_d       = bus.x_in[WIDTH-1] ? 16'h8000 : 16'h0000;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = ITER;
        end
      end
      ITER: begin
        if (!y_q[W-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITERS - 1)) begin
          state_d = POST;
        end
      end
      POST: begin
        mag_d = mag_sat;
        // On the x axis the micro-rotations would leave a table residue;
        // the exact answer is known from the fold, so it is used directly.
        if (on_axis_q) begin
          ang_d = x_neg_q ? 16'h8000 : 16'h0000;
        end else begin
          ang_d = z_q;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mag_q     <= '0;
      ang_q     <= '0;
      on_axis_q <= 1'b0;
      x_neg_q   <= 1'b0;
    end else if (bus.ena) begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mag_q     <= mag_d;
      ang_q     <= ang_d;
      on_axis_q <= on_axis_d;
      x_neg_q   <= x_neg_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.mag_out = mag_q;
  assign bus.ang_out = ang_q;

endmodule

// File: tb/tb_cordic_vector_engine.sv
// Self-checking bench for cordic_vector_engine: one gain-compensated and one
// raw-gain instance share the same stimulus; results are compared with a
// real-arithmetic sqrt/atan2 reference.
module tb_cordic_vector_engine;

  localparam int  WIDTH       = 8;
  localparam int  FRAC        = 8;
  localparam int  ITERS       = 12;
  localparam real LSB_PER_RAD = 65536.0 / 6.283185307179586;
  localparam int  MAG_MAX     = (1 << (WIDTH + 1)) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena_drv;
  logic             start_drv;
  logic [WIDTH-1:0] x_drv;
  logic [WIDTH-1:0] y_drv;

  int n_checks = 0;
  int n_fail   = 0;

  int dir_x [8] = '{-128,    0, -128, 127, 0, 127,   0,   -1};
  int dir_y [8] = '{   0, -128, -128, 127, 0,   0, 127, -128};

  always #5 clk = ~clk;

  cordic_vector_engine_if #(.WIDTH(WIDTH)) cif ();
  cordic_vector_engine_if #(.WIDTH(WIDTH)) rif ();

  assign cif.ena   = ena_drv;
  assign cif.start = start_drv;
  assign cif.x_in  = x_drv;
  assign cif.y_in  = y_drv;
  assign rif.ena   = ena_drv;
  assign rif.start = start_drv;
  assign rif.x_in  = x_drv;
  assign rif.y_in  = y_drv;

  cordic_vector_engine #(
    .WIDTH(WIDTH), .FRAC(FRAC), .ITERS(ITERS), .GAIN_COMP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(cif)
  );

  cordic_vector_engine #(
    .WIDTH(WIDTH), .FRAC(FRAC), .ITERS(ITERS), .GAIN_COMP(0)
  ) dut_raw (
    .clk(clk), .rst_n(rst_n), .bus(rif)
  );

  task automatic check(input string tag, input int obs, input int exp,
                       input int tol, input bit wrap16);
    int d;
    d = obs - exp;
    if (wrap16) begin
      d = d % 65536;
      if (d > 32767)  d = d - 65536;
      if (d < -32768) d = d + 65536;
    end
    n_checks++;
    if (d > tol || d < -tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic real cordic_gain();
    real g;
    g = 1.0;
    for (int i = 0; i < ITERS; i++) g = g * $sqrt(1.0 + $pow(2.0, -2.0 * i));
    return g;
  endfunction

  // Ideal magnitude/angle; angle tolerance widens for short vectors because
  // each truncating shift can move the vector by about one LSB per axis.
  task automatic model(input int xv, input int yv,
                       output int mag_c, output int mag_r, output int mtol,
                       output int ang, output int atol);
    real r;
    r     = $sqrt(real'(xv * xv + yv * yv));
    mag_c = int'(r);
    mag_r = int'(r * cordic_gain());
    if (mag_c > MAG_MAX) mag_c = MAG_MAX;
    if (mag_r > MAG_MAX) mag_r = MAG_MAX;
    if (xv == 0 && yv == 0) begin
      mtol = 0;
      ang  = 0;
      atol = 0;
    end else begin
      mtol = 1;
      ang  = int'($atan2(real'(yv), real'(xv)) * LSB_PER_RAD);
      if (yv == 0) atol = 0;
      else atol = 4 + int'($ceil(3.0 * ITERS * LSB_PER_RAD / (r * $pow(2.0, FRAC))));
    end
  endtask

  task automatic check_result(input string tag, input int xv, input int yv);
    int mc, mr, mt, a, at;
    model(xv, yv, mc, mr, mt, a, at);
    check({tag, "_mag"},     int'(cif.mag_out), mc, mt, 1'b0);
    check({tag, "_ang"},     int'(cif.ang_out), a,  at, 1'b1);
    check({tag, "_rawmag"},  int'(rif.mag_out), mr, mt, 1'b0);
    check({tag, "_rawang"},  int'(rif.ang_out), a,  at, 1'b1);
    check({tag, "_rawdone"}, int'(rif.done),    1,  0,  1'b0);
  endtask

  // Called and returns at a falling edge. Operands are scrambled after the
  // start edge; restart_at pulses start again mid-computation.
  task automatic run_op(input int xv, input int yv, input int stall_at,
                        input int stall_len, input int restart_at,
                        output int lat, output int busy0, output int busy_last);
    int prev;
    x_drv     = WIDTH'(xv);
    y_drv     = WIDTH'(yv);
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    busy0     = int'(cif.busy);
    prev      = busy0;
    lat       = -1;
    busy_last = 0;
    for (int k = 1; k <= ITERS + 64; k++) begin
      @(negedge clk);
      if (cif.done) begin
        lat       = k;
        busy_last = prev;
        break;
      end
      prev      = int'(cif.busy);
      x_drv     = WIDTH'($urandom);
      y_drv     = WIDTH'($urandom);
      start_drv = (k == restart_at);
      if (stall_len > 0 && k == stall_at)             ena_drv = 1'b0;
      if (stall_len > 0 && k == stall_at + stall_len) ena_drv = 1'b1;
    end
    start_drv = 1'b0;
    ena_drv   = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, b0, bl, n_done;
    logic signed [WIDTH-1:0] rx, ry;

    ena_drv   = 1'b1;
    start_drv = 1'b0;
    x_drv     = '0;
    y_drv     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   int'(cif.busy),    0, 0, 1'b0);
    check("rst_done",   int'(cif.done),    0, 0, 1'b0);
    check("rst_mag",    int'(cif.mag_out), 0, 0, 1'b0);
    check("rst_ang",    int'(cif.ang_out), 0, 0, 1'b0);
    check("rst_rawmag", int'(rif.mag_out), 0, 0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3, 4, 0, 0, 0, lat, b0, bl);
    check("p34_lat",        lat, ITERS + 1, 0, 1'b0);
    check("p34_busy_start", b0, 1, 0, 1'b0);
    check("p34_busy_last",  bl, 1, 0, 1'b0);
    check("p34_busy_done",  int'(cif.busy), 0, 0, 1'b0);
    check("p34_mag_exact",  int'(cif.mag_out), 5, 0, 1'b0);
    check_result("p34", 3, 4);
    @(negedge clk);
    check("p34_done_pulse", int'(cif.done), 0, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_op(dir_x[i], dir_y[i], 0, 0, 0, lat, b0, bl);
      check($sformatf("dir%0d_lat", i), lat, ITERS + 1, 0, 1'b0);
      check_result($sformatf("dir%0d", i), dir_x[i], dir_y[i]);
    end

    run_op(10, -20, 0, 0, 3, lat, b0, bl);
    check("restart_lat", lat, ITERS + 1, 0, 1'b0);
    check_result("restart", 10, -20);
    n_done = 0;
    for (int k = 0; k < ITERS + 4; k++) begin
      @(negedge clk);
      if (cif.done) n_done++;
    end
    check("restart_single_done", n_done, 0, 0, 1'b0);

    run_op(-77, 45, 3, 5, 0, lat, b0, bl);
    check("stall_lat", lat, ITERS + 6, 0, 1'b0);
    check_result("stall", -77, 45);
    ena_drv = 1'b0;
    @(negedge clk);
    check("stall_done_held", int'(cif.done), 1, 0, 1'b0);
    ena_drv = 1'b1;
    @(negedge clk);
    check("stall_done_clear", int'(cif.done), 0, 0, 1'b0);
    check("stall_busy_clear", int'(cif.busy), 0, 0, 1'b0);

    for (int n = 0; n < 2000; n++) begin
      rx = WIDTH'($urandom);
      ry = WIDTH'($urandom);
      run_op(int'(rx), int'(ry), 0, 0, 0, lat, b0, bl);
      check($sformatf("rnd%0d_lat", n), lat, ITERS + 1, 0, 1'b0);
      check_result($sformatf("rnd%0d", n), int'(rx), int'(ry));
    end

    @(negedge clk);
    x_drv     = WIDTH'(50);
    y_drv     = WIDTH'(60);
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   int'(cif.busy),    0, 0, 1'b0);
    check("mid_rst_done",   int'(cif.done),    0, 0, 1'b0);
    check("mid_rst_mag",    int'(cif.mag_out), 0, 0, 1'b0);
    check("mid_rst_ang",    int'(cif.ang_out), 0, 0, 1'b0);
    check("mid_rst_rawmag", int'(rif.mag_out), 0, 0, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int k = 0; k < ITERS + 6; k++) begin
      @(negedge clk);
      if (cif.done || rif.done) n_done++;
    end
    check("mid_rst_no_done", n_done, 0, 0, 1'b0);
    check("mid_rst_idle",    int'(cif.busy), 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
